// File: rtl/checkout_pkg.sv
// rtl/checkout_pkg.sv - shared types and constants for the checkout sequencer
package checkout_pkg;

   // Sequencer states: idle, multiply in progress, accumulate, show total
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2,
      SHOW = 2'd3
   } cko_state_t;

   localparam int MUL_CYCLES = 4;
   localparam int PROD_W     = 8;

endpackage

// File: rtl/checkout_sequencer_mul4_seq.sv
// rtl/checkout_sequencer_mul4_seq.sv - 4x4 shift-add sequential multiplier (module mul4_seq)
module mul4_seq
   import checkout_pkg::*;
(
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [3:0]        a,
   input  logic [3:0]        b,
   output logic              done,
   output logic [PROD_W-1:0] p
);

   logic [PROD_W-1:0] mcand;
   logic [3:0]        mplier;
   logic [PROD_W-1:0] acc;
   logic [2:0]        cnt;

   // Load operands on start, then one shift-add step per cycle for four cycles
   always_ff @(posedge CLK) begin
      if (reset || abort) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= {4'b0000, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= 3'(MUL_CYCLES);
      end else if (cnt != 3'd0) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 3'd1;
      end
   end

   // done marks the final step; p holds the full product from the next cycle on
   assign done = (cnt == 3'd1);
   assign p    = acc;

endmodule

// File: rtl/checkout_sequencer.sv
// rtl/checkout_sequencer.sv - checkout item sequencer with saturating running sum; optional pending entry via CHECKOUT_PEND_EN
module checkout_sequencer
   import checkout_pkg::*;
#(
   parameter int SUM_W     = 12,
   parameter int MAX_ITEMS = 15
)(
   input  logic              CLK,
   input  logic              reset,
   input  logic              enter,
   input  logic              total,
   input  logic              clear,
   input  logic [3:0]        cost,
   input  logic [3:0]        qty,
   output logic              busy,
   output logic              item_done,
   output logic [PROD_W-1:0] line_price,
   output logic [SUM_W-1:0]  sum,
   output logic              ovf,
   output logic [3:0]        item_count,
   output logic              full,
   output logic              total_valid
);

   cko_state_t        state, state_nxt;
   logic              mul_start;
   logic              mul_done;
   logic [PROD_W-1:0] mul_p;
   logic              req_valid;
   logic [3:0]        req_cost;
   logic [3:0]        req_qty;
   logic [SUM_W:0]    sum_wide;

`ifdef CHECKOUT_PEND_EN
   logic       pend_valid;
   logic [3:0] pend_cost;
   logic [3:0] pend_qty;

   // One-deep holding slot for an enter that arrives while an item is in flight
   always_ff @(posedge CLK) begin
      if (reset || clear || total) begin
         pend_valid <= 1'b0;
         pend_cost  <= '0;
         pend_qty   <= '0;
      end else if (state == IDLE) begin
         pend_valid <= 1'b0;
      end else if (busy && enter && !pend_valid) begin
         pend_valid <= 1'b1;
         pend_cost  <= cost;
         pend_qty   <= qty;
      end
   end

   assign req_valid = pend_valid | enter;
   assign req_cost  = pend_valid ? pend_cost : cost;
   assign req_qty   = pend_valid ? pend_qty  : qty;
`else
   assign req_valid = enter;
   assign req_cost  = cost;
   assign req_qty   = qty;
`endif

   mul4_seq u_mul (
      .CLK   (CLK),
      .reset (reset),
      .start (mul_start),
      .abort (clear),
      .a     (req_cost),
      .b     (req_qty),
      .done  (mul_done),
      .p     (mul_p)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and multiplier start; clear beats total beats enter
   always_comb begin
      state_nxt = state;
      mul_start = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (total) begin
                  state_nxt = SHOW;
               end else if (req_valid && !full) begin
                  mul_start = 1'b1;
                  state_nxt = MUL;
               end
            end
            MUL: begin
               if (mul_done) begin
                  state_nxt = ACC;
               end
            end
            ACC:     state_nxt = IDLE;
            SHOW:    state_nxt = SHOW;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Carry out of the widened add signals that the sum must clip
   assign sum_wide = {1'b0, sum} + {{(SUM_W - PROD_W + 1){1'b0}}, mul_p};

   // Accumulate the finished product, count the item and pulse item_done
   always_ff @(posedge CLK) begin
      if (reset || clear) begin
         line_price <= '0;
         sum        <= '0;
         ovf        <= 1'b0;
         item_count <= '0;
         item_done  <= 1'b0;
      end else begin
         item_done <= 1'b0;
         if (state == ACC) begin
            line_price <= mul_p;
            item_count <= item_count + 4'd1;
            item_done  <= 1'b1;
            if (sum_wide[SUM_W]) begin
               sum <= '1;
               ovf <= 1'b1;
            end else begin
               sum <= sum_wide[SUM_W-1:0];
            end
         end
      end
   end

   assign busy        = (state == MUL) || (state == ACC);
   assign total_valid = (state == SHOW);
   assign full        = (item_count == 4'(MAX_ITEMS));

endmodule

// File: tb/tb_checkout_sequencer.sv
// tb/tb_checkout_sequencer.sv - self-checking bench for checkout_sequencer
module tb_checkout_sequencer;

   localparam int SW = 8;
   localparam int MI = 3;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic          enter = 1'b0;
   logic          total = 1'b0;
   logic          clear = 1'b0;
   logic [3:0]    cost = '0;
   logic [3:0]    qty = '0;
   logic          busy;
   logic          item_done;
   logic [7:0]    line_price;
   logic [SW-1:0] sum;
   logic          ovf;
   logic [3:0]    item_count;
   logic          full;
   logic          total_valid;

   int nvec = 0;
   int nerr = 0;

   int m_sum, m_cnt, m_lp, m_ovf, m_show;

   checkout_sequencer #(.SUM_W(SW), .MAX_ITEMS(MI)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .enter       (enter),
      .total       (total),
      .clear       (clear),
      .cost        (cost),
      .qty         (qty),
      .busy        (busy),
      .item_done   (item_done),
      .line_price  (line_price),
      .sum         (sum),
      .ovf         (ovf),
      .item_count  (item_count),
      .full        (full),
      .total_valid (total_valid)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".sum"},   32'(sum),         32'(m_sum));
      chk({tag, ".ovf"},   32'(ovf),         32'(m_ovf));
      chk({tag, ".count"}, 32'(item_count),  32'(m_cnt));
      chk({tag, ".lp"},    32'(line_price),  32'(m_lp));
      chk({tag, ".full"},  32'(full),        32'(m_cnt == MI));
      chk({tag, ".tv"},    32'(total_valid), 32'(m_show));
   endtask

   task automatic model_add(input int c, input int q);
      int p;
      p = c * q;
      m_lp = p;
      m_cnt++;
      if (m_sum + p > (1 << SW) - 1) begin
         m_sum = (1 << SW) - 1;
         m_ovf = 1;
      end else begin
         m_sum = m_sum + p;
      end
   endtask

   task automatic model_zero();
      m_sum = 0; m_cnt = 0; m_lp = 0; m_ovf = 0; m_show = 0;
   endtask

   task automatic item(input int c, input int q);
      cost = 4'(c); qty = 4'(q); enter = 1'b1;
      step();
      enter = 1'b0;
      if (m_show != 0 || m_cnt == MI) begin
         chk("ign.busy", 32'(busy), 0);
         step();
         chk("ign.busy2", 32'(busy), 0);
         chk_model("ign");
      end else begin
         chk("e0.busy", 32'(busy), 1);
         for (int i = 0; i < 4; i++) begin
            step();
            chk("run.busy", 32'(busy), 1);
            chk("run.done", 32'(item_done), 0);
         end
         step();
         model_add(c, q);
         chk("e5.busy", 32'(busy), 0);
         chk("e5.done", 32'(item_done), 1);
         chk_model("item");
         step();
         chk("pulse.end", 32'(item_done), 0);
      end
   endtask

   task automatic do_total();
      total = 1'b1;
      step();
      total = 1'b0;
      m_show = 1;
      chk_model("total");
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      model_zero();
      chk("clr.busy", 32'(busy), 0);
      chk_model("clear");
   endtask

   initial begin
      model_zero();
      step();
      step();
      reset = 1'b0;
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(item_done), 0);
      chk_model("rst");

      // basic item, then saturation at SUM_W=8
      item(5, 3);
      item(15, 15);
      item(15, 15);
      // full: further enter ignored
      item(7, 7);
      do_total();
      item(1, 1);
      do_clear();

      // clear two cycles into an item aborts it
      cost = 4'd5; qty = 4'd5; enter = 1'b1;
      step();
      enter = 1'b0;
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      model_zero();
      chk_model("abort");
      for (int i = 0; i < 6; i++) begin
         chk("abort.busy", 32'(busy), 0);
         chk("abort.done", 32'(item_done), 0);
         step();
      end

      // total after 42, enter in SHOW ignored
      item(6, 7);
      do_total();
      item(3, 3);
      do_clear();

      // total and enter together: total wins
      cost = 4'd4; qty = 4'd4; total = 1'b1; enter = 1'b1;
      step();
      total = 1'b0; enter = 1'b0;
      m_show = 1;
      chk("te.busy", 32'(busy), 0);
      step();
      chk("te.busy2", 32'(busy), 0);
      chk_model("te");
      do_clear();

      // enter during MUL: pending only when configured
      cost = 4'd2; qty = 4'd2; enter = 1'b1;
      step();
      enter = 1'b0;
      step();
      cost = 4'd3; qty = 4'd3; enter = 1'b1;
      step();
      enter = 1'b0;
      repeat (3) step();
      chk("pend.first", 32'(sum), 4);
      repeat (6) step();
      model_add(2, 2);
`ifdef CHECKOUT_PEND_EN
      model_add(3, 3);
`endif
      chk_model("pend");
      do_clear();

      // randomized operations against the model
      for (int n = 0; n < 60; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 7) begin
            item(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         end else if (r < 9) begin
            if (m_show == 0) begin
               do_total();
            end else begin
               item(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
         end else begin
            do_clear();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
